// File: rtl/pulse_sync_arbiter.sv
// pulse_sync_arbiter: funnels per-channel event pulses through one shared
// fast-to-slow pulse synchronizer. Each channel counts its pending events.
// The FSM issues one event at a time and then holds for GAP cycles, which
// covers the synchronizer round trip.
//
// Ports
//   clk        fast-domain clock (rising edge)
//   rst        asynchronous active-high reset
//   req_pulse  per-channel single-cycle event pulses (registered on entry)
//   ovf_clr    write-1-to-clear for ovf
//   sync_pulse one-cycle pulse into the shared synchronizer
//   sync_ch    index of the last issued channel, stable until the next issue
//   ovf        sticky per-channel pending-counter overflow flags
//   idle       FSM idle and no events pending
//
// Build option
//   PULSE_ARB_RR_EN defined   : round-robin channel selection
//   PULSE_ARB_RR_EN undefined : fixed priority, lowest index wins
module pulse_sync_arbiter #(
  parameter int CH_W  = 2,
  parameter int CNT_W = 3,
  parameter int GAP   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [2**CH_W-1:0] req_pulse,
  input  logic [2**CH_W-1:0] ovf_clr,
  output logic               sync_pulse,
  output logic [CH_W-1:0]    sync_ch,
  output logic [2**CH_W-1:0] ovf,
  output logic               idle
);
  localparam int NUM_CH = 2**CH_W;
  localparam logic [CNT_W-1:0] CMAX = '1;
  localparam logic [7:0] GAP_LD = 8'(GAP - 1);
  typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;
  state_t state, state_nx;
  logic [NUM_CH-1:0] req_q, nz, dec, sat_set;
  logic [CNT_W-1:0] cnt [NUM_CH];
  logic [7:0] gap;
  logic [CH_W-1:0] sel;
  logic any, go;
  always_comb begin
    nz = '0;
    for (int i = 0; i < NUM_CH; i++) nz[i] = |cnt[i];
  end
  assign any = |nz;
  // go marks every edge that enters ISSUE; it grants sel on that same edge
  assign go = any && (state == IDLE || (state == HOLD && gap == 8'd0));
`ifdef PULSE_ARB_RR_EN
  // ptr holds the search start, i.e. last granted + 1
  logic [CH_W-1:0] ptr;
  always_comb begin
    sel = ptr;
    for (int i = NUM_CH-1; i >= 0; i--)
      if (nz[CH_W'(ptr + CH_W'(i))]) sel = CH_W'(ptr + CH_W'(i));
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) ptr <= '0;
    else if (go) ptr <= sel + 1'b1;
`else
  always_comb begin
    sel = '0;
    for (int i = NUM_CH-1; i >= 0; i--)
      if (nz[i]) sel = CH_W'(i);
  end
`endif
  always_comb begin
    dec = '0;
    sat_set = '0;
    if (go) dec[sel] = 1'b1;
    for (int i = 0; i < NUM_CH; i++) sat_set[i] = req_q[i] && !dec[i] && cnt[i] == CMAX;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  always_comb
    state_nx = go ? ISSUE :
               state == ISSUE ? HOLD :
               (state == HOLD && gap == 8'd0) ? IDLE : state;
  always_comb idle = state == IDLE && !any;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      req_q      <= '0;
      gap        <= '0;
      sync_pulse <= 1'b0;
      sync_ch    <= '0;
      ovf        <= '0;
      for (int i = 0; i < NUM_CH; i++) cnt[i] <= '0;
    end else begin
      req_q      <= req_pulse;
      sync_pulse <= go;
      if (go) sync_ch <= sel;
      gap <= state == ISSUE ? GAP_LD : (state == HOLD && gap != 8'd0) ? gap - 8'd1 : gap;
      // a new overflow wins over a same-edge clear
      ovf <= (ovf & ~ovf_clr) | sat_set;
      // a same-edge increment and grant leave the count unchanged
      for (int i = 0; i < NUM_CH; i++)
        if (req_q[i] && !dec[i]) cnt[i] <= cnt[i] == CMAX ? cnt[i] : cnt[i] + 1'b1;
        else if (dec[i] && !req_q[i]) cnt[i] <= cnt[i] - 1'b1;
    end
endmodule
